// File: rtl/param_regfile_sb.sv
// rtl/param_regfile_sb.sv - parametrised register file with busy scoreboard; write-first bypass under REGFILE_BYPASS_EN
module param_regfile_sb #(
    parameter int DW    = 32,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH),
    parameter int NRD   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegW,
    input  logic [AW-1:0]     DR,
    input  logic [DW-1:0]     data_write,
    input  logic [NRD-1:0]    rd_en,
    input  logic [NRD*AW-1:0] SR,
    output logic [NRD*DW-1:0] SR_out,
    input  logic              sb_set,
    input  logic [AW-1:0]     sb_addr,
    input  logic              sb_clr,
    output logic [NRD-1:0]    busy,
    output logic              any_busy
);

    logic [DW-1:0]     regs [DEPTH];
    logic [DEPTH-1:0]  sb;
    logic [DEPTH-1:0]  sb_next;
    logic [NRD*DW-1:0] rd_next;
    logic              wr_ok;
    logic              sb_set_ok;
    logic              sb_clr_ok;

    assign wr_ok     = RegW && (DR != '0);
    assign sb_set_ok = sb_set && (sb_addr != '0);
    assign sb_clr_ok = sb_clr && (DR != '0);

    // Disabled ports keep their last value; address 0 always yields zero.
    always_comb begin
        rd_next = SR_out;
        for (int k = 0; k < NRD; k++) begin
            if (rd_en[k]) begin
                if (SR[k*AW +: AW] == '0) begin
                    rd_next[k*DW +: DW] = '0;
`ifdef REGFILE_BYPASS_EN
                end else if (wr_ok && (DR == SR[k*AW +: AW])) begin
                    rd_next[k*DW +: DW] = data_write;
`endif
                end else begin
                    rd_next[k*DW +: DW] = regs[SR[k*AW +: AW]];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            SR_out <= '0;
        end else begin
            if (wr_ok) begin
                regs[DR] <= data_write;
            end
            SR_out <= rd_next;
        end
    end

    // Clear is applied before set so a same-address set (newer writer) wins.
    always_comb begin
        sb_next = sb;
        if (sb_clr_ok) begin
            sb_next[DR] = 1'b0;
        end
        if (sb_set_ok) begin
            sb_next[sb_addr] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    always_comb begin
        busy = '0;
        for (int k = 0; k < NRD; k++) begin
            busy[k] = sb[SR[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
            // The value being forwarded is the completing write, so it is not a hazard.
            if (sb_clr && wr_ok && rd_en[k] && (DR == SR[k*AW +: AW])) begin
                busy[k] = 1'b0;
            end
`endif
        end
    end

    assign any_busy = |sb[DEPTH-1:1];

endmodule

// File: tb/tb_param_regfile_sb.sv
// tb/tb_param_regfile_sb.sv - randomized model-checked bench for param_regfile_sb
module tb_param_regfile_sb;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;

    logic              clk;
    logic              rst;
    logic              RegW;
    logic [AW-1:0]     DR;
    logic [DW-1:0]     data_write;
    logic [NRD-1:0]    rd_en;
    logic [NRD*AW-1:0] SR;
    logic [NRD*DW-1:0] SR_out;
    logic              sb_set;
    logic [AW-1:0]     sb_addr;
    logic              sb_clr;
    logic [NRD-1:0]    busy;
    logic              any_busy;

    int n_vec;
    int n_err;
    bit check_en;

    logic [DW-1:0]    m_reg [DEPTH];
    logic [DEPTH-1:0] m_sb;
    logic [DW-1:0]    m_out [NRD];
    logic [DEPTH-1:0] set_mask;
    logic [DEPTH-1:0] clr_mask;

    param_regfile_sb #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .NRD(NRD)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegW       (RegW),
        .DR         (DR),
        .data_write (data_write),
        .rd_en      (rd_en),
        .SR         (SR),
        .SR_out     (SR_out),
        .sb_set     (sb_set),
        .sb_addr    (sb_addr),
        .sb_clr     (sb_clr),
        .busy       (busy),
        .any_busy   (any_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (RegW && DR != 0 && DR == a) return data_write;
`endif
        return m_reg[a];
    endfunction

    function automatic logic model_busy(input int k);
        logic [AW-1:0] a;
        a = SR[k*AW +: AW];
`ifdef REGFILE_BYPASS_EN
        if (sb_clr && RegW && rd_en[k] && DR != 0 && DR == a) return 1'b0;
`endif
        return m_sb[a];
    endfunction

    // Reference model: state after each edge from the inputs seen at that edge.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
            for (int k = 0; k < NRD; k++) m_out[k] = '0;
            m_sb = '0;
        end else begin
            for (int k = 0; k < NRD; k++)
                if (rd_en[k]) m_out[k] = model_read(SR[k*AW +: AW]);
            if (RegW && DR != 0) m_reg[DR] = data_write;
            set_mask = (sb_set && sb_addr != 0) ? (DEPTH'(1) << sb_addr) : '0;
            clr_mask = (sb_clr && DR != 0) ? (DEPTH'(1) << DR) : '0;
            m_sb = (m_sb & ~clr_mask) | set_mask;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < NRD; k++) begin
                check($sformatf("sr_out%0d", k), 64'(SR_out[k*DW +: DW]), 64'(m_out[k]));
                check($sformatf("busy%0d", k), 64'(busy[k]), 64'(model_busy(k)));
            end
            check("any_busy", 64'(any_busy), 64'(|m_sb));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RegW = 0; DR = '0; data_write = '0; rd_en = '0; SR = '0;
        sb_set = 0; sb_addr = '0; sb_clr = 0; rst = 0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 1) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;
        check_en = 0;
        idle();
        rst = 1;
        tick();
        tick();
        check_en = 1;
        rst = 0;
        check("reset_out", 64'(SR_out), 64'h0);
        check("reset_any_busy", 64'(any_busy), 64'h0);

        // reset discards earlier write
        RegW = 1; DR = 5; data_write = 32'hDEADBEEF;
        tick();
        idle(); rst = 1;
        tick();
        idle(); rd_en = 2'b01; SR[0 +: AW] = 5;
        tick();
        check("rst_r5", 64'(SR_out[0 +: DW]), 64'h0);
        check("rst_busy", 64'(busy[0]), 64'h0);
        check("rst_any", 64'(any_busy), 64'h0);

        // basic write/read on both ports
        idle(); RegW = 1; DR = 3; data_write = 32'h12345678;
        tick();
        DR = 7; data_write = 32'hCAFEF00D;
        tick();
        idle(); rd_en = 2'b11; SR = {AW'(7), AW'(3)};
        tick();
        check("port0_r3", 64'(SR_out[0 +: DW]), 64'h12345678);
        check("port1_r7", 64'(SR_out[DW +: DW]), 64'hCAFEF00D);
        rd_en = 2'b10; SR[0 +: AW] = 9;
        tick();
        check("port0_hold", 64'(SR_out[0 +: DW]), 64'h12345678);

        // r0 protection
        idle(); RegW = 1; DR = 0; data_write = 32'hFFFFFFFF; sb_set = 1; sb_addr = 0;
        tick();
        idle(); rd_en = 2'b01;
        tick();
        check("r0_read", 64'(SR_out[0 +: DW]), 64'h0);
        check("r0_busy", 64'(busy[0]), 64'h0);
        check("r0_any", 64'(any_busy), 64'h0);

        // same-cycle write/read of r9
        idle(); RegW = 1; DR = 9; data_write = 32'h1;
        tick();
        data_write = 32'h2; rd_en = 2'b01; SR[0 +: AW] = 9;
        tick();
`ifdef REGFILE_BYPASS_EN
        check("r9_same", 64'(SR_out[0 +: DW]), 64'h2);
`else
        check("r9_same", 64'(SR_out[0 +: DW]), 64'h1);
`endif
        RegW = 0;
        tick();
        check("r9_next", 64'(SR_out[0 +: DW]), 64'h2);

        // scoreboard set / set-wins / clear
        idle(); sb_set = 1; sb_addr = 4; SR[0 +: AW] = 4;
        tick();
        check("sb_set_busy", 64'(busy[0]), 64'h1);
        sb_clr = 1; DR = 4;
        tick();
        check("sb_setwins", 64'(busy[0]), 64'h1);
        sb_set = 0;
        tick();
        check("sb_clr_busy", 64'(busy[0]), 64'h0);
        check("sb_clr_any", 64'(any_busy), 64'h0);

        // mid-operation reset
        idle(); RegW = 1; DR = 6; data_write = 32'h55; sb_set = 1; sb_addr = 6;
        tick();
        check("r6_pending", 64'(any_busy), 64'h1);
        idle(); RegW = 1; DR = 6; data_write = 32'h77; rst = 1;
        tick();
        check("mid_rst_any", 64'(any_busy), 64'h0);
        idle(); rd_en = 2'b01; SR[0 +: AW] = 6;
        tick();
        check("mid_rst_r6", 64'(SR_out[0 +: DW]), 64'h0);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst        = ($urandom_range(0, 99) == 0);
            RegW       = $urandom_range(0, 1) == 1;
            DR         = rand_addr();
            data_write = $urandom;
            rd_en      = NRD'($urandom_range(0, (1 << NRD) - 1));
            for (int k = 0; k < NRD; k++) SR[k*AW +: AW] = rand_addr();
            sb_set     = $urandom_range(0, 2) != 0;
            sb_addr    = rand_addr();
            sb_clr     = $urandom_range(0, 2) != 0;
            tick();
        end
        idle();
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
